// File: rtl/ps2_key_typer.sv
// Auto-typer: turns accepted ASCII characters into timed PS/2 make/break events on
// the 65-bit ps2_key bus so the keyboard matrix decoder sees real keystrokes.
module ps2_key_typer #(
    parameter int HOLD_CYCLES = 800000,
    parameter int GAP_CYCLES  = 800000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        abort,
    output logic [64:0] ps2_key,
    output logic        busy,
    output logic        dropped
);
    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [7:0] LSHIFT = 8'h12;

    typedef enum logic [2:0] {IDLE, SH_DN, KEY_DN, KEY_UP, SH_UP, WAIT, GAP} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [7:0]    code_q;
    logic          shift_q, key_down, shift_down;
    logic [9:0]    map;
    logic          accept, emit;
    logic [7:0]    emit_code, emit_pfx, cur_code;

    // {mappable, needs_shift, scancode}; letters fold to lower case (PET upper-case mode)
    function automatic logic [9:0] map_ascii(input logic [7:0] c);
        logic [7:0] l;
        l = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
        case (l)
            8'h61: map_ascii = {2'b10, 8'h1C};  8'h62: map_ascii = {2'b10, 8'h32};
            8'h63: map_ascii = {2'b10, 8'h21};  8'h64: map_ascii = {2'b10, 8'h23};
            8'h65: map_ascii = {2'b10, 8'h24};  8'h66: map_ascii = {2'b10, 8'h2B};
            8'h67: map_ascii = {2'b10, 8'h34};  8'h68: map_ascii = {2'b10, 8'h33};
            8'h69: map_ascii = {2'b10, 8'h43};  8'h6A: map_ascii = {2'b10, 8'h3B};
            8'h6B: map_ascii = {2'b10, 8'h42};  8'h6C: map_ascii = {2'b10, 8'h4B};
            8'h6D: map_ascii = {2'b10, 8'h3A};  8'h6E: map_ascii = {2'b10, 8'h31};
            8'h6F: map_ascii = {2'b10, 8'h44};  8'h70: map_ascii = {2'b10, 8'h4D};
            8'h71: map_ascii = {2'b10, 8'h15};  8'h72: map_ascii = {2'b10, 8'h2D};
            8'h73: map_ascii = {2'b10, 8'h1B};  8'h74: map_ascii = {2'b10, 8'h2C};
            8'h75: map_ascii = {2'b10, 8'h3C};  8'h76: map_ascii = {2'b10, 8'h2A};
            8'h77: map_ascii = {2'b10, 8'h1D};  8'h78: map_ascii = {2'b10, 8'h22};
            8'h79: map_ascii = {2'b10, 8'h35};  8'h7A: map_ascii = {2'b10, 8'h1A};
            8'h30: map_ascii = {2'b10, 8'h45};  8'h31: map_ascii = {2'b10, 8'h16};
            8'h32: map_ascii = {2'b10, 8'h1E};  8'h33: map_ascii = {2'b10, 8'h26};
            8'h34: map_ascii = {2'b10, 8'h25};  8'h35: map_ascii = {2'b10, 8'h2E};
            8'h36: map_ascii = {2'b10, 8'h36};  8'h37: map_ascii = {2'b10, 8'h3D};
            8'h38: map_ascii = {2'b10, 8'h3E};  8'h39: map_ascii = {2'b10, 8'h46};
            8'h20: map_ascii = {2'b10, 8'h29};  8'h0D: map_ascii = {2'b10, 8'h5A};
            8'h08: map_ascii = {2'b10, 8'h66};  8'h1B: map_ascii = {2'b10, 8'h76};
            8'h2C: map_ascii = {2'b10, 8'h41};  8'h2E: map_ascii = {2'b10, 8'h49};
            8'h2F: map_ascii = {2'b10, 8'h4A};  8'h3B: map_ascii = {2'b10, 8'h4C};
            8'h2D: map_ascii = {2'b10, 8'h4E};  8'h27: map_ascii = {2'b10, 8'h52};
            8'h3D: map_ascii = {2'b10, 8'h55};  8'h5B: map_ascii = {2'b10, 8'h54};
            8'h5D: map_ascii = {2'b10, 8'h5B};  8'h5C: map_ascii = {2'b10, 8'h5D};
            8'h21: map_ascii = {2'b11, 8'h16};  8'h40: map_ascii = {2'b11, 8'h1E};
            8'h23: map_ascii = {2'b11, 8'h26};  8'h24: map_ascii = {2'b11, 8'h25};
            8'h25: map_ascii = {2'b11, 8'h2E};  8'h5E: map_ascii = {2'b11, 8'h36};
            8'h26: map_ascii = {2'b11, 8'h3D};  8'h2A: map_ascii = {2'b11, 8'h3E};
            8'h28: map_ascii = {2'b11, 8'h46};  8'h29: map_ascii = {2'b11, 8'h45};
            8'h3C: map_ascii = {2'b11, 8'h41};  8'h3E: map_ascii = {2'b11, 8'h49};
            8'h3F: map_ascii = {2'b11, 8'h4A};  8'h3A: map_ascii = {2'b11, 8'h4C};
            8'h5F: map_ascii = {2'b11, 8'h4E};  8'h22: map_ascii = {2'b11, 8'h52};
            8'h2B: map_ascii = {2'b11, 8'h55};
            default: map_ascii = 10'd0;
        endcase
    endfunction

    assign map        = map_ascii(char_in);
    assign char_ready = (state == IDLE) & ~abort & ~reset;
    assign accept     = char_valid & char_ready;
    assign busy       = (state != IDLE);
    assign cur_code   = (state == IDLE) ? map[7:0] : code_q;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept && map[9]) next = map[8] ? SH_DN : KEY_DN;
            SH_DN:   next = WAIT;
            KEY_DN:  next = WAIT;
            WAIT:    if (cnt == '0) next = key_down ? KEY_UP : KEY_DN;
            KEY_UP:  next = shift_q ? SH_UP : GAP;
            SH_UP:   next = GAP;
            GAP:     if (cnt == '0) next = IDLE;
            default: next = IDLE;
        endcase
        // Abort releases whatever is held, key first, then shift; never lingers in GAP
        if (abort && state != IDLE) begin
            if (key_down)        next = KEY_UP;
            else if (shift_down) next = SH_UP;
            else                 next = IDLE;
        end
    end

    // Emitting states last one cycle, so the event is registered on entry and is
    // visible for the whole cycle the FSM spends in that state.
    always_comb begin
        emit      = 1'b0;
        emit_pfx  = 8'h00;
        emit_code = cur_code;
        case (next)
            SH_DN:   begin emit = 1'b1; emit_code = LSHIFT; end
            KEY_DN:  emit = 1'b1;
            KEY_UP:  begin emit = 1'b1; emit_pfx = 8'hF0; end
            SH_UP:   begin emit = 1'b1; emit_pfx = 8'hF0; emit_code = LSHIFT; end
            default: emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            code_q     <= 8'h00;
            shift_q    <= 1'b0;
            key_down   <= 1'b0;
            shift_down <= 1'b0;
            ps2_key    <= '0;
            dropped    <= 1'b0;
        end else begin
            state   <= next;
            dropped <= accept & ~map[9];
            if (accept && map[9]) begin
                code_q  <= map[7:0];
                shift_q <= map[8];
            end
            if (next == WAIT && state != WAIT)     cnt <= CW'(HOLD_CYCLES - 1);
            else if (next == GAP && state != GAP)  cnt <= CW'(GAP_CYCLES - 1);
            else if (next == IDLE)                 cnt <= '0;
            else if (cnt != '0)                    cnt <= cnt - 1'b1;
            if (emit) ps2_key <= {~ps2_key[64], 48'd0, emit_pfx, emit_code};
            if (next == KEY_DN) key_down <= 1'b1;
            if (next == KEY_UP) key_down <= 1'b0;
            if (next == SH_DN)  shift_down <= 1'b1;
            if (next == SH_UP)  shift_down <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_key_typer.sv
// Directed bench for ps2_key_typer (HOLD_CYCLES=8, GAP_CYCLES=4); a negedge monitor
// logs every toggle of ps2_key[64] with its cycle number for the tests to inspect.
module tb_ps2_key_typer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        abort = 1'b0;
    logic        char_ready, busy, dropped;
    logic [64:0] ps2_key;

    typedef struct { int cyc; logic [63:0] key; } ev_t;
    ev_t  ev_q[$];
    int   ncyc = 0;
    logic prev_tog = 1'b0;
    int   n_vec = 0, n_fail = 0;

    ps2_key_typer #(.HOLD_CYCLES(8), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .abort(abort), .ps2_key(ps2_key),
        .busy(busy), .dropped(dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        ev_t e;
        ncyc++;
        if (ps2_key[64] !== prev_tog) begin
            e.cyc = ncyc;
            e.key = ps2_key[63:0];
            ev_q.push_back(e);
            prev_tog = ps2_key[64];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, output int acc);
        int k = 0;
        while (!char_ready && k < 200) begin step(); k++; end
        if (!char_ready) begin
            n_vec++; n_fail++;
            $display("FAIL send_timeout char=%h ready=%b required 1", c, char_ready);
        end
        char_in = c; char_valid = 1'b1; acc = ncyc;
        step();
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) step();
        n_vec++; if (ps2_key !== 65'd0) begin n_fail++; $display("FAIL rst_key got %h want 0", ps2_key); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL rst_dropped got %b want 0", dropped); end
        n_vec++; if (char_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", char_ready); end
        reset = 1'b0;
        step();
        n_vec++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", char_ready); end
        ev_q.delete();
    endtask

    task automatic test_letter();
        int a, busy_cnt = 0, rdy = -1;
        logic [63:0] ek[2] = '{64'h001C, 64'hF01C};
        int          eo[2] = '{1, 10};
        ev_q.delete();
        send_char(8'h61, a);
        for (int k = 0; k < 20; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (char_ready === 1'b1 && rdy < 0) rdy = ncyc;
            step();
        end
        n_vec++; if (ev_q.size() != 2) begin n_fail++; $display("FAIL a_count got %0d want 2", ev_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= ev_q.size() || ev_q[i].key !== ek[i] || ev_q[i].cyc != a + eo[i]) begin
                n_fail++;
                $display("FAIL a_ev%0d got %h@%0d want %h@%0d", i,
                         (i < ev_q.size()) ? ev_q[i].key : 64'hx, (i < ev_q.size()) ? ev_q[i].cyc - a : -1, ek[i], eo[i]);
            end
        end
        n_vec++; if (busy_cnt != 14) begin n_fail++; $display("FAIL a_busy_cycles got %0d want 14", busy_cnt); end
        n_vec++; if (rdy != a + 15) begin n_fail++; $display("FAIL a_ready_at got %0d want 15", rdy - a); end
    endtask

    task automatic test_shift();
        int a;
        logic [63:0] ek[4] = '{64'h0012, 64'h0016, 64'hF016, 64'hF012};
        int          eo[4] = '{1, 10, 19, 20};
        ev_q.delete();
        send_char(8'h21, a);
        repeat (26) step();
        n_vec++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL bang_count got %0d want 4", ev_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= ev_q.size() || ev_q[i].key !== ek[i] || ev_q[i].cyc != a + eo[i]) begin
                n_fail++;
                $display("FAIL bang_ev%0d got %h@%0d want %h@%0d", i,
                         (i < ev_q.size()) ? ev_q[i].key : 64'hx, (i < ev_q.size()) ? ev_q[i].cyc - a : -1, ek[i], eo[i]);
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] cs[2] = '{8'h80, 8'h7E};
        int a;
        for (int i = 0; i < 2; i++) begin
            ev_q.delete();
            send_char(cs[i], a);
            n_vec++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop%0d_pulse got %b want 1", i, dropped); end
            n_vec++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL drop%0d_ready got %b want 1", i, char_ready); end
            step();
            n_vec++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL drop%0d_once got %b want 0", i, dropped); end
            repeat (10) step();
            n_vec++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL drop%0d_events got %0d want 0", i, ev_q.size()); end
        end
    endtask

    task automatic test_abort();
        int a;
        logic [63:0] ek[4] = '{64'h0012, 64'h0052, 64'hF052, 64'hF012};
        int          eo[4] = '{1, 10, 14, 15};
        ev_q.delete();
        send_char(8'h22, a);
        while (ncyc < a + 13) step();
        abort = 1'b1;
        while (ncyc < a + 16) step();
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle busy got %b want 0", busy); end
        n_vec++; if (char_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_held got %b want 0", char_ready); end
        abort = 1'b0;
        #1;
        n_vec++; if (char_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_release got %b want 1", char_ready); end
        repeat (5) step();
        n_vec++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL abort_count got %0d want 4", ev_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= ev_q.size() || ev_q[i].key !== ek[i] || ev_q[i].cyc != a + eo[i]) begin
                n_fail++;
                $display("FAIL abort_ev%0d got %h@%0d want %h@%0d", i,
                         (i < ev_q.size()) ? ev_q[i].key : 64'hx, (i < ev_q.size()) ? ev_q[i].cyc - a : -1, ek[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  cs[3] = '{8'h48, 8'h49, 8'h0D};
        logic [63:0] ek[6] = '{64'h0033, 64'hF033, 64'h0043, 64'hF043, 64'h005A, 64'hF05A};
        ev_q.delete();
        char_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            char_in = cs[i];
            while (!char_ready && k < 200) begin step(); k++; end
            if (!char_ready) begin n_vec++; n_fail++; $display("FAIL stream_timeout idx=%0d ready=%b required 1", i, char_ready); end
            step();
        end
        char_valid = 1'b0;
        repeat (20) step();
        n_vec++; if (ev_q.size() != 6) begin n_fail++; $display("FAIL stream_count got %0d want 6", ev_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (i >= ev_q.size() || ev_q[i].key !== ek[i]) begin
                n_fail++;
                $display("FAIL stream_ev%0d got %h want %h", i, (i < ev_q.size()) ? ev_q[i].key : 64'hx, ek[i]);
            end
        end
        if (ev_q.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (ev_q[2*i+1].cyc - ev_q[2*i].cyc != 9) begin
                    n_fail++; $display("FAIL stream_hold%0d got %0d want 9", i, ev_q[2*i+1].cyc - ev_q[2*i].cyc);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (ev_q[2*i].cyc - ev_q[2*i-1].cyc < 5) begin
                    n_fail++; $display("FAIL stream_gap%0d got %0d want >=5", i, ev_q[2*i].cyc - ev_q[2*i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int a, b;
        logic [63:0] ek[2] = '{64'h001A, 64'hF01A};
        int          eo[2] = '{1, 10};
        send_char(8'h61, a);
        while (ncyc < a + 5) step();
        reset = 1'b1;
        #1;
        n_vec++; if (ps2_key !== 65'd0) begin n_fail++; $display("FAIL midrst_key got %h want 0", ps2_key); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        step();
        reset = 1'b0;
        step();
        ev_q.delete();
        send_char(8'h7A, b);
        repeat (20) step();
        n_vec++; if (ev_q.size() != 2) begin n_fail++; $display("FAIL z_count got %0d want 2", ev_q.size()); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (i >= ev_q.size() || ev_q[i].key !== ek[i] || ev_q[i].cyc != b + eo[i]) begin
                n_fail++;
                $display("FAIL z_ev%0d got %h@%0d want %h@%0d", i,
                         (i < ev_q.size()) ? ev_q[i].key : 64'hx, (i < ev_q.size()) ? ev_q[i].cyc - b : -1, ek[i], eo[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d, required completion", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_letter();
        test_shift();
        test_drop();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
